// File: rtl/rst_sequencer.sv
// rst_sequencer: staged, synchronously released, active-low reset generator.
// Assertion is immediate. Release waits for PLL lock and a clean push-button
// input, then frees each downstream reset domain in index order with a fixed
// gap between stages. Faults seen while releasing or running restart the
// whole sequence and record their cause.
// Optional watchdog: define RST_SEQ_WDT_EN to add the i_wdt_kick port and the
// WDT_CYC parameter.
module rst_sequencer #(
    parameter int NUM_STAGES   = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int HOLD_CYC     = 8,
    parameter int STAGE_GAP    = 4
`ifdef RST_SEQ_WDT_EN
    ,
    parameter int WDT_CYC      = 1000
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_ext_rst_n,
    input  logic                  i_pll_locked,
    input  logic                  i_sw_rst,
`ifdef RST_SEQ_WDT_EN
    input  logic                  i_wdt_kick,
`endif
    output logic [NUM_STAGES-1:0] o_rst_n,
    output logic                  o_busy,
    output logic [1:0]            o_state,
    output logic [2:0]            o_cause
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_t;

    // One shared counter covers both the HOLD window and the inter-stage gap.
    localparam int CNT_MAX = (HOLD_CYC > STAGE_GAP) ? HOLD_CYC : STAGE_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STG_W   = $clog2(NUM_STAGES + 1);
    localparam int DBC_W   = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]            r_ext_sync;
    logic [1:0]            r_lock_sync;
    logic                  w_ext_s;
    logic                  w_lock_s;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [STG_W-1:0]      r_stage;      // index of the next stage to release
    logic [STG_W-1:0]      w_stage_nxt;
    logic [NUM_STAGES-1:0] r_rst_n;
    logic [NUM_STAGES-1:0] w_rst_n_nxt;
    logic [2:0]            r_cause;
    logic [2:0]            w_cause_nxt;
    logic [DBC_W-1:0]      r_dbc;
    logic                  w_active;
    logic                  w_pll_fault;
    logic                  w_ext_fault;
    logic                  w_sw_fault;
    logic                  w_wdt_fault;

    // Two-flop synchronisers for the asynchronous push-button and PLL lock inputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ext_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_ext_sync  <= {r_ext_sync[0], i_ext_rst_n};
            r_lock_sync <= {r_lock_sync[0], i_pll_locked};
        end
    end

    assign w_ext_s  = r_ext_sync[1];
    assign w_lock_s = r_lock_sync[1];

    // Debounce: count consecutive synced-low cycles, saturating at the press threshold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dbc <= '0;
        end else if (w_ext_s) begin
            r_dbc <= '0;
        end else if (r_dbc != DBC_W'(DEBOUNCE_CYC - 1)) begin
            r_dbc <= r_dbc + 1'b1;
        end
    end

    assign w_active    = (r_state == ST_RELEASE) || (r_state == ST_RUN);
    assign w_pll_fault = w_active && !w_lock_s;
    assign w_ext_fault = w_active && !w_ext_s && (r_dbc == DBC_W'(DEBOUNCE_CYC - 1));
    assign w_sw_fault  = (r_state == ST_RUN) && i_sw_rst;

`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYC + 1);

    logic [WDT_W-1:0] r_wdt;

    // Watchdog: runs only in RUN, cleared by a kick, held at zero elsewhere.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdt <= '0;
        end else if ((r_state != ST_RUN) || i_wdt_kick) begin
            r_wdt <= '0;
        end else if (r_wdt != WDT_W'(WDT_CYC - 1)) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

    assign w_wdt_fault = (r_state == ST_RUN) && !i_wdt_kick &&
                         (r_wdt == WDT_W'(WDT_CYC - 1));
`else
    assign w_wdt_fault = 1'b0;
`endif

    // State register and registered reset outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_stage <= '0;
            r_rst_n <= '0;
            r_cause <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stage <= w_stage_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    // Next-state logic: faults override everything, otherwise step the sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stage_nxt = r_stage;
        w_rst_n_nxt = r_rst_n;
        w_cause_nxt = r_cause;

        if (w_pll_fault || w_ext_fault || w_sw_fault || w_wdt_fault) begin
            w_state_nxt = ST_ASSERT;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
            w_rst_n_nxt = '0;
            if (w_pll_fault)      w_cause_nxt = 3'd1;
            else if (w_ext_fault) w_cause_nxt = 3'd2;
            else if (w_sw_fault)  w_cause_nxt = 3'd3;
            else                  w_cause_nxt = 3'd4;
        end else begin
            case (r_state)
                ST_ASSERT: begin
                    w_rst_n_nxt = '0;
                    w_cnt_nxt   = '0;
                    w_stage_nxt = '0;
                    if (w_lock_s && w_ext_s) w_state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    if (!w_lock_s || !w_ext_s) begin
                        w_state_nxt = ST_ASSERT;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == CNT_W'(HOLD_CYC - 1)) begin
                        w_rst_n_nxt[0] = 1'b1;
                        w_cnt_nxt      = '0;
                        w_stage_nxt    = STG_W'(1);
                        w_state_nxt    = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == CNT_W'(STAGE_GAP - 1)) begin
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (r_stage == STG_W'(k)) w_rst_n_nxt[k] = 1'b1;
                        end
                        w_cnt_nxt   = '0;
                        w_stage_nxt = r_stage + 1'b1;
                        if (r_stage == STG_W'(NUM_STAGES - 1)) w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    w_state_nxt = ST_RUN;
                end
                default: begin
                    w_state_nxt = ST_ASSERT;
                end
            endcase
        end
    end

    assign o_rst_n = r_rst_n;
    assign o_busy  = (r_state != ST_RUN);
    assign o_state = r_state;
    assign o_cause = r_cause;

endmodule

// File: tb/tb_rst_sequencer.sv
// Testbench for rst_sequencer: release timing table replayed from several
// starting points, plus hand-written fault, priority and async-reset sequences.
`timescale 1ns/1ps
module tb_rst_sequencer;

    localparam int NS = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ext_n = 1'b1;
    logic          lock  = 1'b1;
    logic          sw    = 1'b0;
`ifdef RST_SEQ_WDT_EN
    logic          kick  = 1'b1;
`endif
    logic [NS-1:0] o_rst_n;
    logic          busy;
    logic [1:0]    state;
    logic [2:0]    cause;

    rst_sequencer #(
        .NUM_STAGES(NS)
`ifdef RST_SEQ_WDT_EN
        , .WDT_CYC(20)
`endif
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_ext_rst_n  (ext_n),
        .i_pll_locked (lock),
        .i_sw_rst     (sw),
`ifdef RST_SEQ_WDT_EN
        .i_wdt_kick   (kick),
`endif
        .o_rst_n      (o_rst_n),
        .o_busy       (busy),
        .o_state      (state),
        .o_cause      (cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [NS-1:0] rst;
        logic          busy;
        logic [1:0]    st;
        logic [2:0]    cause;
    } exp_t;

    typedef struct {
        int            e;
        logic [NS-1:0] rst;
        logic          busy;
        logic [1:0]    st;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[10];
    int   n_checks = 0;
    int   n_err    = 0;
    int   edge_n   = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [NS-1:0] r, input logic b,
                              input logic [1:0] s, input logic [2:0] c);
        exp_t x;
        x.name  = nm;
        x.rst   = r;
        x.busy  = b;
        x.st    = s;
        x.cause = c;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty at edge %0d", edge_n);
            return;
        end
        x = sb.pop_front();
        if (o_rst_n !== x.rst || busy !== x.busy || state !== x.st || cause !== x.cause) begin
            n_err++;
            $display("FAIL %s edge %0d: got rst_n=%b busy=%b state=%0d cause=%0d, expected rst_n=%b busy=%b state=%0d cause=%0d",
                     x.name, edge_n, o_rst_n, busy, state, cause, x.rst, x.busy, x.st, x.cause);
        end
    endtask

    task automatic chk(input string nm, input logic [NS-1:0] r, input logic b,
                       input logic [1:0] s, input logic [2:0] c);
        expect_out(nm, r, b, s, c);
        check_out();
    endtask

    // Replays the release table relative to 'base' (edge base+1 behaves like
    // edge 1 after power-on). sw_at>0 drives a one-cycle i_sw_rst high at edge
    // base+sw_at. Entries beyond last_e are not visited.
    task automatic run_seq(input int base, input logic [2:0] c, input int sw_at,
                           input int last_e, input string tag);
        for (int i = 0; i < 10; i++) begin
            int tgt;
            if (tbl[i].e > last_e) break;
            tgt = base + tbl[i].e;
            if (tgt <= edge_n) continue;
            while (edge_n < tgt) begin
                if (edge_n + 1 == base + sw_at) sw = 1'b1;
                tick(1);
                sw = 1'b0;
            end
            expect_out($sformatf("%s_e%0d", tag, tbl[i].e), tbl[i].rst, tbl[i].busy, tbl[i].st, c);
            check_out();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    initial begin
        int base;

        tbl[0] = '{2,  4'b0000, 1'b1, 2'd0};
        tbl[1] = '{3,  4'b0000, 1'b1, 2'd1};
        tbl[2] = '{10, 4'b0000, 1'b1, 2'd1};
        tbl[3] = '{11, 4'b0001, 1'b1, 2'd2};
        tbl[4] = '{14, 4'b0001, 1'b1, 2'd2};
        tbl[5] = '{15, 4'b0011, 1'b1, 2'd2};
        tbl[6] = '{18, 4'b0011, 1'b1, 2'd2};
        tbl[7] = '{19, 4'b0111, 1'b1, 2'd2};
        tbl[8] = '{22, 4'b0111, 1'b1, 2'd2};
        tbl[9] = '{23, 4'b1111, 1'b0, 2'd3};

        // Power-on: held in reset, then released before edge 1.
        tick(3);
        chk("por_hold", 4'b0000, 1'b1, 2'd0, 3'd0);
        rst_n  = 1'b1;
        edge_n = 0;
        run_seq(0, 3'd0, 0, 99, "por");

        // Push-button low for 15 cycles: no effect.
        ext_n = 1'b0;
        tick(15);
        ext_n = 1'b1;
        tick(2);
        chk("ext15_last", 4'b1111, 1'b0, 2'd3, 3'd0);
        tick(3);
        chk("ext15_after", 4'b1111, 1'b0, 2'd3, 3'd0);

        // Push-button low for 16 cycles: reset with cause EXT.
        ext_n = 1'b0;
        tick(17);
        chk("ext16_pre", 4'b1111, 1'b0, 2'd3, 3'd0);
        tick(1);
        chk("ext16_fault", 4'b0000, 1'b1, 2'd0, 3'd2);
        tick(4);
        chk("ext16_held", 4'b0000, 1'b1, 2'd0, 3'd2);
        ext_n = 1'b1;
        // Re-release with a software pulse in HOLD that must be ignored.
        run_seq(edge_n, 3'd2, 5, 99, "ext_rerel");

        // Software pulse in RUN: reset with cause SW, immediate re-release.
        run_seq(edge_n - 1, 3'd3, 2, 99, "sw_run");

        // PLL loss coinciding with a software pulse: PLL wins.
        lock = 1'b0;
        tick(2);
        chk("pll_pre", 4'b1111, 1'b0, 2'd3, 3'd3);
        sw = 1'b1;
        tick(1);
        sw = 1'b0;
        chk("pll_sw_prio", 4'b0000, 1'b1, 2'd0, 3'd1);
        tick(6);
        chk("pll_wait", 4'b0000, 1'b1, 2'd0, 3'd1);
        lock = 1'b1;
        run_seq(edge_n, 3'd1, 0, 15, "pll_rel");

        // Lock loss with two stages released: everything drops next edge.
        lock = 1'b0;
        tick(2);
        chk("rel_pre", 4'b0011, 1'b1, 2'd2, 3'd1);
        tick(1);
        chk("rel_lockloss", 4'b0000, 1'b1, 2'd0, 3'd1);
        lock = 1'b1;
        // Full sequence again, with a software pulse in RELEASE that must be ignored.
        run_seq(edge_n, 3'd1, 13, 99, "rel_rerel");

`ifdef RST_SEQ_WDT_EN
        // Watchdog: regular kicks keep RUN, silence trips cause 4.
        kick = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(9);
            kick = 1'b1;
            tick(1);
            kick = 1'b0;
            chk("wdt_kicked", 4'b1111, 1'b0, 2'd3, 3'd1);
        end
        tick(19);
        chk("wdt_pre", 4'b1111, 1'b0, 2'd3, 3'd1);
        tick(1);
        chk("wdt_fault", 4'b0000, 1'b1, 2'd0, 3'd4);
        kick = 1'b1;
        run_seq(edge_n - 2, 3'd4, 0, 99, "wdt_rerel");
`endif

        // Asynchronous reset in the middle of RELEASE.
        run_seq(edge_n - 1, 3'd3, 2, 16, "sw_mid");
        chk("mid_release", 4'b0011, 1'b1, 2'd2, 3'd3);
        rst_n = 1'b0;
        #2;
        chk("async_rst", 4'b0000, 1'b1, 2'd0, 3'd0);
        tick(2);
        chk("async_held", 4'b0000, 1'b1, 2'd0, 3'd0);
        rst_n = 1'b1;
        base  = edge_n;
        run_seq(base, 3'd0, 0, 99, "por2");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
